// File: rtl/sumador_pkg.sv
// Shared types and helpers for the sumador arithmetic library.
// Holds the sequential adder FSM states and an index-width helper.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Width of a chunk index; never narrower than one bit.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/sumador_secuencial_if.sv
// Handshake and operand/result bundle of the sequential adder.
// master drives requests, slave is the adder itself.
interface sumador_secuencial_if #(
    parameter int NUM_BITS = 16
);
    logic                start;
    logic                resta;
    logic                Cin;
    logic [NUM_BITS-1:0] A;
    logic [NUM_BITS-1:0] B;
    logic                ready;
    logic                done;
    logic [NUM_BITS-1:0] S;
    logic                C;
    logic                V;
    logic                N;
    logic                Z;

    modport master (
        output start, resta, Cin, A, B,
        input  ready, done, S, C, V, N, Z
    );

    modport slave (
        input  start, resta, Cin, A, B,
        output ready, done, S, C, V, N, Z
    );
endinterface

// File: rtl/sumador.sv
// Combinational ripple adder with carry-out and signed overflow.
// Used as the per-slice datapath of the sequential adder.
module sumador #(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                Cin,
    output logic [NUM_BITS-1:0] S,
    output logic                C,
    output logic                V
);
    logic [NUM_BITS-2:0] low_s;
    logic                c_msb;
    logic                s_msb;

    // Lower bits first so the carry into the MSB is visible for V.
    assign {c_msb, low_s} = {1'b0, A[NUM_BITS-2:0]}
                          + {1'b0, B[NUM_BITS-2:0]}
                          + {{(NUM_BITS-1){1'b0}}, Cin};

    assign {C, s_msb} = {1'b0, A[NUM_BITS-1]}
                      + {1'b0, B[NUM_BITS-1]}
                      + {1'b0, c_msb};

    assign S = {s_msb, low_s};
    assign V = c_msb ^ C;
endmodule

// File: rtl/sumador_secuencial.sv
// Multi-cycle adder/subtractor: CHUNK_BITS per clock, registered carry.
// Result and N/Z/C/V flags are committed together when the last slice lands.
module sumador_secuencial
    import sumador_pkg::*;
#(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input logic                clk,
    input logic                rst,
    sumador_secuencial_if.slave bus
);
    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int KW         = idx_width(NUM_CHUNKS);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

    estado_t             st_q, st_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] sh_q, sh_d;
    logic [NUM_BITS-1:0] s_q, s_d;
    logic [KW-1:0]       k_q, k_d;
    logic                cy_q, cy_d;
    logic                c_q, c_d;
    logic                v_q, v_d;
    logic                n_q, n_d;
    logic                z_q, z_d;

    logic [CHUNK_BITS-1:0] a_sl, b_sl, sl_s;
    logic                  sl_c, sl_v;
    logic                  rdy;
    logic                  acc;

    assign rdy = (st_q == IDLE) || (st_q == DONE);
    assign acc = bus.start && rdy;

    // Pick the operand slice addressed by the chunk index.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[i*CHUNK_BITS +: CHUNK_BITS];
                b_sl = b_q[i*CHUNK_BITS +: CHUNK_BITS];
            end
        end
    end

    sumador #(
        .NUM_BITS(CHUNK_BITS)
    ) u_slice (
        .A  (a_sl),
        .B  (b_sl),
        .Cin(cy_q),
        .S  (sl_s),
        .C  (sl_c),
        .V  (sl_v)
    );

    // Next-state logic: slice accumulation, commit and request acceptance.
    always_comb begin
        st_d = st_q;
        a_d  = a_q;
        b_d  = b_q;
        sh_d = sh_q;
        s_d  = s_q;
        k_d  = k_q;
        cy_d = cy_q;
        c_d  = c_q;
        v_d  = v_q;
        n_d  = n_q;
        z_d  = z_q;

        unique case (st_q)
            IDLE: st_d = IDLE;
            CALC: begin
                for (int i = 0; i < NUM_CHUNKS; i++) begin
                    if (k_q == KW'(i)) begin
                        sh_d[i*CHUNK_BITS +: CHUNK_BITS] = sl_s;
                    end
                end
                cy_d = sl_c;
                k_d  = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    st_d = DONE;
                    k_d  = '0;
                    s_d  = sh_d;
                    c_d  = sl_c;
                    v_d  = sl_v;
                    n_d  = sh_d[NUM_BITS-1];
                    z_d  = (sh_d == '0);
                end
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase

        // Subtraction is A + ~B + ~Cin, so B and the carry are folded here.
        if (acc) begin
            st_d = CALC;
            k_d  = '0;
            a_d  = bus.A;
            b_d  = bus.resta ? ~bus.B : bus.B;
            cy_d = bus.resta ? ~bus.Cin : bus.Cin;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            a_q  <= '0;
            b_q  <= '0;
            sh_q <= '0;
            s_q  <= '0;
            k_q  <= '0;
            cy_q <= 1'b0;
            c_q  <= 1'b0;
            v_q  <= 1'b0;
            n_q  <= 1'b0;
            z_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            a_q  <= a_d;
            b_q  <= b_d;
            sh_q <= sh_d;
            s_q  <= s_d;
            k_q  <= k_d;
            cy_q <= cy_d;
            c_q  <= c_d;
            v_q  <= v_d;
            n_q  <= n_d;
            z_q  <= z_d;
        end
    end

    assign bus.ready = rdy;
    assign bus.done  = (st_q == DONE);
    assign bus.S     = s_q;
    assign bus.C     = c_q;
    assign bus.V     = v_q;
    assign bus.N     = n_q;
    assign bus.Z     = z_q;
endmodule

// File: tb/tb_sumador_secuencial.sv
// Self-checking bench for sumador_secuencial (16-bit, 4-bit slices).
// Cycle model from plain arithmetic plus hand-computed directed results.
module tb_sumador_secuencial;
    localparam int NB = 16;
    localparam int CB = 4;
    localparam int NC = NB / CB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sumador_secuencial_if #(.NUM_BITS(NB)) bus ();

    sumador_secuencial #(
        .NUM_BITS  (NB),
        .CHUNK_BITS(CB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: result from whole-word arithmetic, timing as a countdown.
    int          m_cnt = 0;
    logic [15:0] m_S, p_S;
    logic        m_C, m_V, m_N, m_Z, m_done;
    logic        p_C, p_V;

    task automatic model_calc(input logic [15:0] a, input logic [15:0] b,
                              input logic r, input logic cin,
                              output logic [15:0] s, output logic c,
                              output logic v);
        logic [15:0] bo;
        logic        ci;
        logic [16:0] full;
        bo   = r ? ~b : b;
        ci   = r ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bo} + {16'd0, ci};
        s    = full[15:0];
        c    = full[16];
        v    = (a[15] == bo[15]) && (s[15] != a[15]);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_S    = '0;
            m_C    = 1'b0;
            m_V    = 1'b0;
            m_N    = 1'b0;
            m_Z    = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_S    = p_S;
                    m_C    = p_C;
                    m_V    = p_V;
                    m_N    = p_S[15];
                    m_Z    = (p_S == 16'h0000);
                    m_done = 1'b1;
                end
            end else if (bus.start) begin
                model_calc(bus.A, bus.B, bus.resta, bus.Cin, p_S, p_C, p_V);
                m_cnt = NC;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.ready", bus.ready, (m_cnt == 0));
            chk("m.done", bus.done, m_done);
            chk("m.S", bus.S, m_S);
            chk("m.C", bus.C, m_C);
            chk("m.V", bus.V, m_V);
            chk("m.N", bus.N, m_N);
            chk("m.Z", bus.Z, m_Z);
        end
    end

    int lat;

    task automatic go(input logic [15:0] a, input logic [15:0] b,
                      input logic r, input logic cin);
        @(posedge clk);
        #1;
        bus.A     = a;
        bus.B     = b;
        bus.resta = r;
        bus.Cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic expect_res(input string nm, input logic [15:0] s,
                              input logic c, input logic v,
                              input logic n, input logic z);
        chk({nm, ".done"}, bus.done, 1'b1);
        chk({nm, ".S"}, bus.S, s);
        chk({nm, ".C"}, bus.C, c);
        chk({nm, ".V"}, bus.V, v);
        chk({nm, ".N"}, bus.N, n);
        chk({nm, ".Z"}, bus.Z, z);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.resta = 1'b0;
        bus.Cin   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst.ready", bus.ready, 1'b1);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.S", bus.S, 16'h0000);
        rst = 1'b0;

        go(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(lat);
        chk("t1.lat", lat, NC);
        expect_res("t1", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        go(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        expect_res("t2a", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        go(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        expect_res("t2b", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);

        go(16'h0005, 16'h0007, 1'b1, 1'b0);
        wait_done(lat);
        expect_res("t3a", 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);

        go(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_done(lat);
        expect_res("t3b", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        go(16'h00FF, 16'h0000, 1'b0, 1'b1);
        wait_done(lat);
        expect_res("t4", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start pulse mid-operation must be dropped.
        go(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.A     = 16'hAAAA;
        bus.B     = 16'h5555;
        bus.resta = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        expect_res("t5a", 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back request issued in the done cycle.
        bus.A     = 16'h0001;
        bus.B     = 16'h0002;
        bus.resta = 1'b0;
        bus.Cin   = 1'b0;
        bus.start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            if (!bus.done) chk("t5.hold", bus.S, 16'h3333);
        end while (!bus.done && lat < 20);
        chk("t5.lat", lat, NC + 1);
        expect_res("t5b", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset two cycles into an operation aborts it without a done.
        go(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6.ready", bus.ready, 1'b1);
        chk("t6.done", bus.done, 1'b0);
        chk("t6.S", bus.S, 16'h0000);
        chk("t6.flags", {bus.C, bus.V, bus.N, bus.Z}, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t6.nodone", bus.done, 1'b0);
        end

        go(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_done(lat);
        chk("t6.lat", lat, NC);
        expect_res("t6", 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
